axi_stream_to_bt656: RTL and testbench
======================================

Name: axi_stream_to_bt656

Overview:
- Transmit-side counterpart of the BT.656 receive path: takes AXI4-Stream YCbCr 4:2:2 video and serialises it into an 8-bit BT.656 byte stream.
- Inserts EAV/SAV timing codes, horizontal blanking and vertical blanking lines.
- Progressive only (F=0). Used for loopback of VDMA read-back or test-pattern video to an external encoder.
- Emits one byte per pix_ce_i cycle.

Parameters:
- DW, 32, AXI stream data width; only 32 is supported, other values are an elaboration error.

Ports:
- axi_clk_i  in  1  single clock.
- axi_rstn_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  start/continue frame generation.
- pix_ce_i  in  1  byte-rate clock enable; one output byte per cycle in which it is high.
- cfg_width_i  in  11  active pixels per line; even, >=2.
- cfg_height_i  in  11  active lines; >=1.
- cfg_hblank_i  in  10  blanking bytes between EAV and SAV; multiple of 4, >=4.
- cfg_vblank_i  in  8  vertical blanking lines; >=1.
- s_tdata  in  32  {Y1,Cr,Y0,Cb}; Cb at [7:0] goes on the wire first.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- s_tuser  in  1  start of frame (first beat of frame).
- s_tlast  in  1  end of line (last beat of line).
- bt656_data_o  out  8  BT.656 byte.
- bt656_valid_o  out  1  bt656_data_o updated this cycle (registered pix_ce_i).
- frame_start_o  out  1  one-cycle pulse when EAV of vblank line 0 is emitted.
- underflow_o  out  1  one-cycle pulse per active 4-byte group filled with blank data.

Behaviour:
- Reset values: bt656_data_o=8'h00, bt656_valid_o=0, s_tready=0, frame_start_o=0, underflow_o=0, FSM=IDLE, all counters 0. Reset mid-frame aborts immediately.
- All state advances only on cycles with pix_ce_i=1. Output is registered: the byte selected in cycle N appears in cycle N+1 with bt656_valid_o=1.
- FSM states: IDLE, EAV, HBLANK, SAV, ACTIVE.
  - IDLE: leave when enable_i=1 and pix_ce_i=1. Latch cfg_* at this point; line counter=0.
  - EAV: 4 bytes.
  - HBLANK: cfg_hblank_i bytes.
  - SAV: 4 bytes.
  - ACTIVE: 2*cfg_width_i bytes.
  - After ACTIVE, advance the line counter and go to EAV.
- Frame: lines 0..cfg_vblank_i-1 are blanking (V=1); the next cfg_height_i lines are active (V=0).
- At the end of the last active line: if enable_i=1, re-latch cfg_* and go to EAV with line=0; otherwise go to IDLE. Deasserting enable_i mid-frame always completes the frame.
- Timing codes:
  - Code bytes: FF 00 00 XY, with XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}.
  - Active lines: EAV XY=9D, SAV XY=80.
  - Blanking lines: EAV XY=B6, SAV XY=AB.
- Blank data: alternating 80,10 starting with 80. Applies to HBLANK and to the ACTIVE region of vblank lines.
- Active data:
  - At byte phase 0 of each 4-byte group, if s_tvalid=1, assert s_tready for exactly that cycle, capture s_tdata into the holding register, then output bytes [7:0],[15:8],[23:16],[31:24].
  - If s_tvalid=0, emit 80 10 80 10 for the group, pulse underflow_o, and do not consume a beat.
- Frame sync:
  - During vblank lines, beats with s_tuser=0 are flushed (s_tready=1, data discarded).
  - A beat with s_tuser=1 is held (s_tready=0) until the first group of active line 0.
  - If the first group of active line 0 sees a valid beat without s_tuser, it is consumed and output, and later frames resync on the next vblank.
- Line sync:
  - Early s_tlast (before the last group): remaining groups of the line are blank, with no underflow pulse.
  - Last group consumed with s_tlast=0: during the following EAV/HBLANK, flush beats (s_tready=1) up to and including one with s_tlast=1. A flushed s_tuser beat stops the flush and is held.
- pix_ce_i=0: outputs hold except bt656_valid_o=0. s_tready is only ever high on cycles with pix_ce_i=1.
- Simultaneous: enable_i falling in the same cycle as the last active byte → IDLE, frame_start_o not pulsed.

Optional Feature:
- Macro BT656_TX_STATS_EN. When defined:
  - Adds outputs underflow_cnt_o[15:0] (increments per underflow_o pulse, saturates at FFFF) and frame_cnt_o[15:0] (increments per frame_start_o, wraps).
  - Both counters cleared by reset only.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- width=4, height=2, hblank=4, vblank=1, pix_ce_i=1, stream always valid, s_tdata beats 0x44332211, 0x88776655 → exact sequence:
  - Line 0: FF 00 00 B6, 80 10 80 10, FF 00 00 AB, 80 10 80 10 80 10 80 10.
  - Line 1: FF 00 00 9D, 80 10 80 10, FF 00 00 80, 11 22 33 44 55 66 77 88.
  - frame_start_o pulses once, on the first byte.
- Active line with s_tvalid=0 for the second beat → bytes 80 10 80 10 in that slot, underflow_o pulses once, the next line's data is unaffected.
- Two junk beats (s_tuser=0) presented during vblank → both flushed, first active output is the s_tuser beat data.
- pix_ce_i high every 2nd cycle → output sequence identical to the first scenario, bt656_valid_o toggles, s_tready never high while pix_ce_i=0.
- enable_i dropped mid-frame → frame completes to the last active byte, then IDLE. Asserting axi_rstn_i=0 mid-line → next cycle all outputs at reset values.
- BT656_TX_STATS_EN defined, 3 frames with 5 underflow groups → frame_cnt_o=3, underflow_cnt_o=5.

Source files
------------

// File: rtl/axi_stream_to_bt656.sv
// AXI4-Stream YCbCr 4:2:2 to 8-bit BT.656 serialiser (progressive, F=0).
// Define BT656_TX_STATS_EN to add the underflow_cnt_o / frame_cnt_o statistics outputs.
module axi_stream_to_bt656 #(
    parameter int DW = 32
) (
    input  logic          axi_clk_i,
    input  logic          axi_rstn_i,
    input  logic          enable_i,
    input  logic          pix_ce_i,
    input  logic [10:0]   cfg_width_i,
    input  logic [10:0]   cfg_height_i,
    input  logic [9:0]    cfg_hblank_i,
    input  logic [7:0]    cfg_vblank_i,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tuser,
    input  logic          s_tlast,
    output logic [7:0]    bt656_data_o,
    output logic          bt656_valid_o,
    output logic          frame_start_o,
    output logic          underflow_o
`ifdef BT656_TX_STATS_EN
    ,
    output logic [15:0]   underflow_cnt_o,
    output logic [15:0]   frame_cnt_o
`endif
);

    if (DW != 32) begin : g_dw_check
        $error("axi_stream_to_bt656: DW must be 32");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_EAV, ST_HBLANK, ST_SAV, ST_ACTIVE} state_t;

    state_t      state;
    logic [11:0] cnt;
    logic [11:0] line;
    logic [10:0] w_l;
    logic [10:0] h_l;
    logic [9:0]  hb_l;
    logic [7:0]  vb_l;
    logic [31:0] hold;
    logic        grp_blank;
    logic        line_done;
    logic        flush_pend;

    logic [11:0] act_bytes;
    logic        vblank_line;
    logic        last_line;
    logic        act_last;
    logic        last_grp;
    logic        grp_slot;
    logic        take;
    logic        flush_win;
    logic        flush_take;
    logic        uf_set;
    logic        fs_set;
    logic        start_frame;
    logic [7:0]  xy;
    logic [7:0]  code_byte;
    logic [7:0]  blank_byte;
    logic [7:0]  hold_byte;

    always_comb begin
        act_bytes   = {w_l, 1'b0};
        vblank_line = line < {4'b0, vb_l};
        last_line   = line == ({4'b0, vb_l} + {1'b0, h_l} - 12'd1);
        act_last    = cnt == act_bytes - 12'd1;
        last_grp    = cnt == act_bytes - 12'd4;
        // A group slot only exists at byte phase 0 of an active line not already ended by s_tlast.
        grp_slot    = (state == ST_ACTIVE) && !vblank_line && (cnt[1:0] == 2'd0) && !line_done;
        take        = grp_slot && s_tvalid;
        flush_win   = (vblank_line && (state != ST_IDLE)) ||
                      (flush_pend && ((state == ST_EAV) || (state == ST_HBLANK)));
        flush_take  = flush_win && s_tvalid && !s_tuser;
        s_tready    = pix_ce_i && (take || flush_take);
        uf_set      = pix_ce_i && grp_slot && !s_tvalid;
        fs_set      = pix_ce_i && (state == ST_EAV) && (cnt == 12'd0) && (line == 12'd0);
        start_frame = pix_ce_i && enable_i &&
                      ((state == ST_IDLE) || ((state == ST_ACTIVE) && act_last && last_line));

        if (vblank_line) xy = (state == ST_EAV) ? 8'hB6 : 8'hAB;
        else             xy = (state == ST_EAV) ? 8'h9D : 8'h80;
        case (cnt[1:0])
            2'd0:    code_byte = 8'hFF;
            2'd3:    code_byte = xy;
            default: code_byte = 8'h00;
        endcase
        blank_byte = cnt[0] ? 8'h10 : 8'h80;
        case (cnt[1:0])
            2'd1:    hold_byte = hold[15:8];
            2'd2:    hold_byte = hold[23:16];
            2'd3:    hold_byte = hold[31:24];
            default: hold_byte = hold[7:0];
        endcase
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            line          <= '0;
            w_l           <= '0;
            h_l           <= '0;
            hb_l          <= '0;
            vb_l          <= '0;
            hold          <= '0;
            grp_blank     <= 1'b0;
            line_done     <= 1'b0;
            flush_pend    <= 1'b0;
            bt656_data_o  <= '0;
            bt656_valid_o <= 1'b0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            bt656_valid_o <= pix_ce_i;
            frame_start_o <= fs_set;
            underflow_o   <= uf_set;
            if (start_frame) begin
                w_l  <= cfg_width_i;
                h_l  <= cfg_height_i;
                hb_l <= cfg_hblank_i;
                vb_l <= cfg_vblank_i;
                line <= '0;
            end
            if (pix_ce_i) begin
                // A stale-line flush ends at the s_tlast beat or at an s_tuser beat, which stays held.
                if (flush_pend && s_tvalid && (s_tuser || s_tlast) &&
                    ((state == ST_EAV) || (state == ST_HBLANK)))
                    flush_pend <= 1'b0;
                unique case (state)
                    ST_IDLE: begin
                        bt656_data_o <= 8'h10;
                        if (enable_i) begin
                            state      <= ST_EAV;
                            cnt        <= '0;
                            line_done  <= 1'b0;
                            flush_pend <= 1'b0;
                        end
                    end
                    ST_EAV: begin
                        bt656_data_o <= code_byte;
                        if (cnt == 12'd3) begin
                            cnt   <= '0;
                            state <= ST_HBLANK;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                    ST_HBLANK: begin
                        bt656_data_o <= blank_byte;
                        if (cnt == {2'b0, hb_l} - 12'd1) begin
                            cnt   <= '0;
                            state <= ST_SAV;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                    ST_SAV: begin
                        bt656_data_o <= code_byte;
                        flush_pend   <= 1'b0;
                        if (cnt == 12'd3) begin
                            cnt   <= '0;
                            state <= ST_ACTIVE;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (vblank_line) begin
                            bt656_data_o <= blank_byte;
                        end else if (cnt[1:0] == 2'd0) begin
                            if (take) begin
                                bt656_data_o <= s_tdata[7:0];
                                hold         <= s_tdata[31:0];
                                grp_blank    <= 1'b0;
                                if (s_tlast && !last_grp) line_done  <= 1'b1;
                                if (!s_tlast && last_grp) flush_pend <= 1'b1;
                            end else begin
                                bt656_data_o <= blank_byte;
                                grp_blank    <= 1'b1;
                            end
                        end else begin
                            bt656_data_o <= grp_blank ? blank_byte : hold_byte;
                        end
                        if (act_last) begin
                            cnt       <= '0;
                            line_done <= 1'b0;
                            if (!last_line) begin
                                line  <= line + 12'd1;
                                state <= ST_EAV;
                            end else if (enable_i) begin
                                state <= ST_EAV;
                            end else begin
                                line  <= '0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef BT656_TX_STATS_EN
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            underflow_cnt_o <= '0;
            frame_cnt_o     <= '0;
        end else begin
            if (uf_set && (underflow_cnt_o != 16'hFFFF)) underflow_cnt_o <= underflow_cnt_o + 16'd1;
            if (fs_set) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_to_bt656.sv
// Scoreboard bench for axi_stream_to_bt656: expected byte stream queued with the stimulus.
// Statistics outputs are checked when BT656_TX_STATS_EN is defined.
module tb_axi_stream_to_bt656;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        pix_ce;
    logic [10:0] cfg_w;
    logic [10:0] cfg_h;
    logic [9:0]  cfg_hb;
    logic [7:0]  cfg_vb;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic [7:0]  bt656_data;
    logic        bt656_valid;
    logic        frame_start;
    logic        underflow;
`ifdef BT656_TX_STATS_EN
    logic [15:0] uf_cnt;
    logic [15:0] fr_cnt;
`endif

    axi_stream_to_bt656 #(.DW(32)) dut (
        .axi_clk_i    (clk),
        .axi_rstn_i   (rstn),
        .enable_i     (enable),
        .pix_ce_i     (pix_ce),
        .cfg_width_i  (cfg_w),
        .cfg_height_i (cfg_h),
        .cfg_hblank_i (cfg_hb),
        .cfg_vblank_i (cfg_vb),
        .s_tdata      (tdata),
        .s_tvalid     (tvalid),
        .s_tready     (tready),
        .s_tuser      (tuser),
        .s_tlast      (tlast),
        .bt656_data_o (bt656_data),
        .bt656_valid_o(bt656_valid),
        .frame_start_o(frame_start),
        .underflow_o  (underflow)
`ifdef BT656_TX_STATS_EN
        ,
        .underflow_cnt_o(uf_cnt),
        .frame_cnt_o    (fr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] d; logic u; logic l;} beat_t;
    typedef struct packed {logic [7:0] d; logic fs; logic uf;} exp_t;

    beat_t bq[$];
    exp_t  eq[$];
    int    checks = 0;
    int    errors = 0;

    function automatic beat_t mk(input logic [31:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        return b;
    endfunction

    task automatic push_b(input logic [7:0] d, input logic fs, input logic uf);
        exp_t e;
        e.d = d; e.fs = fs; e.uf = uf;
        eq.push_back(e);
    endtask

    task automatic push_blank(input int n, input logic uf);
        for (int i = 0; i < n; i++) push_b((i % 2) ? 8'h10 : 8'h80, 1'b0, uf && (i == 0));
    endtask

    task automatic push_hdr(input logic vline, input logic first, input int hb);
        push_b(8'hFF, first, 1'b0); push_b(8'h00, 1'b0, 1'b0); push_b(8'h00, 1'b0, 1'b0);
        push_b(vline ? 8'hB6 : 8'h9D, 1'b0, 1'b0);
        push_blank(hb, 1'b0);
        push_b(8'hFF, 1'b0, 1'b0); push_b(8'h00, 1'b0, 1'b0); push_b(8'h00, 1'b0, 1'b0);
        push_b(vline ? 8'hAB : 8'h80, 1'b0, 1'b0);
    endtask

    task automatic push_word(input logic [31:0] d);
        push_b(d[7:0], 1'b0, 1'b0);   push_b(d[15:8], 1'b0, 1'b0);
        push_b(d[23:16], 1'b0, 1'b0); push_b(d[31:24], 1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int vb);
        cfg_w = 11'(w); cfg_h = 11'(h); cfg_hb = 10'(hb); cfg_vb = 8'(vb);
        bq.delete(); eq.delete();
    endtask

    // One clock: drive the source from the beat queue, observe handshake before the edge.
    task automatic step(input logic pce, output logic rbad);
        logic hs;
        pix_ce = pce;
        if (bq.size() > 0) begin
            tvalid = 1'b1; tdata = bq[0].d; tuser = bq[0].u; tlast = bq[0].l;
        end else begin
            tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
        end
        #3;
        hs   = tvalid && tready;
        rbad = tready && !pce;
        @(posedge clk); #1;
        if (hs) bq.delete(0);
    endtask

    task automatic test_reset();
        logic rbad;
        rstn = 1'b0; enable = 1'b0; pix_ce = 1'b0;
        tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
        set_cfg(4, 2, 4, 1);
        #2;
        checks++;
        if ({bt656_data, bt656_valid, tready, frame_start, underflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: data=%h valid=%b ready=%b fs=%b uf=%b, expected 00 0 0 0 0",
                     bt656_data, bt656_valid, tready, frame_start, underflow);
        end
        #10 rstn = 1'b1;
        @(posedge clk); #1;
        bq.push_back(mk(32'hDEADBEEF, 1'b0, 1'b0));
        for (int c = 0; c < 4; c++) step(1'b1, rbad);
        checks++;
        if (bq.size() != 1) begin
            errors++;
            $display("FAIL idle_no_ready: beats left=%0d, expected 1", bq.size());
        end
        bq.delete();
    endtask

    task automatic test_frame(input int div);
        exp_t e; logic rbad; logic pce; int fsn = 0; int ufn = 0; int n = 0; bit armed = 0;
        set_cfg(4, 2, 4, 1);
        bq.push_back(mk(32'h44332211, 1'b1, 1'b0)); bq.push_back(mk(32'h88776655, 1'b0, 1'b1));
        bq.push_back(mk(32'hCCBBAA99, 1'b0, 1'b0)); bq.push_back(mk(32'h00FFEEDD, 1'b0, 1'b1));
        push_hdr(1'b1, 1'b1, 4); push_blank(8, 1'b0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h44332211); push_word(32'h88776655);
        push_hdr(1'b0, 1'b0, 4); push_word(32'hCCBBAA99); push_word(32'h00FFEEDD);
        enable = 1'b1;
        for (int c = 0; c < 70 * div; c++) begin
            pce = ((c % div) == 0);
            step(pce, rbad);
            if (c == 0) enable = 1'b0;
            checks++;
            if (rbad || (bt656_valid !== pce)) begin
                errors++;
                $display("FAIL ce_gating div%0d cyc%0d: valid=%b ready_without_ce=%b, expected valid=%b ready_without_ce=0",
                         div, c, bt656_valid, rbad, pce);
            end
            if (bt656_valid && frame_start) armed = 1;
            if (armed && bt656_valid && eq.size() > 0) begin
                e = eq.pop_front(); checks++;
                if ({bt656_data, frame_start, underflow} !== {e.d, e.fs, e.uf}) begin
                    errors++;
                    $display("FAIL frame div%0d byte%0d: data=%h fs=%b uf=%b, expected %h %b %b",
                             div, n, bt656_data, frame_start, underflow, e.d, e.fs, e.uf);
                end
                n++;
            end
            if (frame_start) fsn++;
            if (underflow) ufn++;
        end
        checks++;
        if (eq.size() != 0 || bq.size() != 0 || fsn != 1 || ufn != 0) begin
            errors++;
            $display("FAIL frame_end div%0d: bytes left=%0d beats left=%0d fs=%0d uf=%0d, expected 0 0 1 0",
                     div, eq.size(), bq.size(), fsn, ufn);
        end
    endtask

    task automatic test_underflow();
        exp_t e; logic rbad; int ufn = 0; int n = 0; bit armed = 0;
        set_cfg(4, 2, 4, 1);
        bq.push_back(mk(32'h44332211, 1'b1, 1'b0));
        push_hdr(1'b1, 1'b1, 4); push_blank(8, 1'b0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h44332211); push_blank(4, 1'b1);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h0BADF00D); push_word(32'h12345678);
        enable = 1'b1;
        for (int c = 0; c < 70; c++) begin
            step(1'b1, rbad);
            enable = 1'b0;
            if (bt656_valid && frame_start) armed = 1;
            if (armed && bt656_valid && eq.size() > 0) begin
                e = eq.pop_front(); checks++;
                if ({bt656_data, frame_start, underflow} !== {e.d, e.fs, e.uf}) begin
                    errors++;
                    $display("FAIL underflow byte%0d: data=%h fs=%b uf=%b, expected %h %b %b",
                             n, bt656_data, frame_start, underflow, e.d, e.fs, e.uf);
                end
                n++;
            end
            if (underflow) begin
                ufn++;
                if (ufn == 1) begin
                    bq.push_back(mk(32'h0BADF00D, 1'b0, 1'b0));
                    bq.push_back(mk(32'h12345678, 1'b0, 1'b1));
                end
            end
        end
        checks++;
        if (eq.size() != 0 || bq.size() != 0 || ufn != 1) begin
            errors++;
            $display("FAIL underflow_end: bytes left=%0d beats left=%0d uf=%0d, expected 0 0 1",
                     eq.size(), bq.size(), ufn);
        end
    endtask

    task automatic test_vblank_flush();
        exp_t e; logic rbad; int n = 0; bit armed = 0;
        set_cfg(4, 1, 4, 2);
        bq.push_back(mk(32'hAAAAAAAA, 1'b0, 1'b0)); bq.push_back(mk(32'hBBBBBBBB, 1'b0, 1'b1));
        bq.push_back(mk(32'h44332211, 1'b1, 1'b0)); bq.push_back(mk(32'h88776655, 1'b0, 1'b1));
        push_hdr(1'b1, 1'b1, 4); push_blank(8, 1'b0);
        push_hdr(1'b1, 1'b0, 4); push_blank(8, 1'b0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h44332211); push_word(32'h88776655);
        enable = 1'b1;
        for (int c = 0; c < 70; c++) begin
            step(1'b1, rbad);
            enable = 1'b0;
            if (bt656_valid && frame_start) armed = 1;
            if (armed && bt656_valid && eq.size() > 0) begin
                e = eq.pop_front(); checks++;
                if ({bt656_data, frame_start, underflow} !== {e.d, e.fs, e.uf}) begin
                    errors++;
                    $display("FAIL vblank_flush byte%0d: data=%h fs=%b uf=%b, expected %h %b %b",
                             n, bt656_data, frame_start, underflow, e.d, e.fs, e.uf);
                end
                n++;
            end
        end
        checks++;
        if (eq.size() != 0 || bq.size() != 0) begin
            errors++;
            $display("FAIL vblank_flush_end: bytes left=%0d beats left=%0d, expected 0 0", eq.size(), bq.size());
        end
    endtask

    task automatic test_line_sync();
        exp_t e; logic rbad; int ufn = 0; int n = 0; bit armed = 0;
        set_cfg(4, 3, 4, 1);
        bq.push_back(mk(32'h44332211, 1'b1, 1'b1));
        bq.push_back(mk(32'hC3C2C1C0, 1'b0, 1'b0)); bq.push_back(mk(32'hD3D2D1D0, 1'b0, 1'b0));
        bq.push_back(mk(32'hE3E2E1E0, 1'b0, 1'b1));
        bq.push_back(mk(32'h63626160, 1'b0, 1'b0)); bq.push_back(mk(32'h73727170, 1'b0, 1'b1));
        push_hdr(1'b1, 1'b1, 4); push_blank(8, 1'b0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h44332211); push_blank(4, 1'b0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'hC3C2C1C0); push_word(32'hD3D2D1D0);
        push_hdr(1'b0, 1'b0, 4); push_word(32'h63626160); push_word(32'h73727170);
        enable = 1'b1;
        for (int c = 0; c < 90; c++) begin
            step(1'b1, rbad);
            enable = 1'b0;
            if (bt656_valid && frame_start) armed = 1;
            if (armed && bt656_valid && eq.size() > 0) begin
                e = eq.pop_front(); checks++;
                if ({bt656_data, frame_start, underflow} !== {e.d, e.fs, e.uf}) begin
                    errors++;
                    $display("FAIL line_sync byte%0d: data=%h fs=%b uf=%b, expected %h %b %b",
                             n, bt656_data, frame_start, underflow, e.d, e.fs, e.uf);
                end
                n++;
            end
            if (underflow) ufn++;
        end
        checks++;
        if (eq.size() != 0 || bq.size() != 0 || ufn != 0) begin
            errors++;
            $display("FAIL line_sync_end: bytes left=%0d beats left=%0d uf=%0d, expected 0 0 0",
                     eq.size(), bq.size(), ufn);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic rbad; int fsn = 0; int ufn = 0; int n = 0; bit armed = 0;
        rstn = 1'b0; #2 rstn = 1'b1;
        @(posedge clk); #1;
        set_cfg(2, 2, 4, 1);
        bq.push_back(mk(32'h44332211, 1'b1, 1'b1));
        for (int f = 0; f < 3; f++) begin
            push_hdr(1'b1, 1'b1, 4); push_blank(4, 1'b0);
            push_hdr(1'b0, 1'b0, 4);
            if (f == 0) push_word(32'h44332211); else push_blank(4, 1'b1);
            push_hdr(1'b0, 1'b0, 4); push_blank(4, 1'b1);
        end
        enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step(1'b1, rbad);
            if (bt656_valid && frame_start) armed = 1;
            if (armed && bt656_valid && eq.size() > 0) begin
                e = eq.pop_front(); checks++;
                if ({bt656_data, frame_start, underflow} !== {e.d, e.fs, e.uf}) begin
                    errors++;
                    $display("FAIL back_to_back byte%0d: data=%h fs=%b uf=%b, expected %h %b %b",
                             n, bt656_data, frame_start, underflow, e.d, e.fs, e.uf);
                end
                n++;
            end
            if (frame_start) fsn++;
            if (underflow) ufn++;
            if (fsn == 3) enable = 1'b0;
        end
        checks++;
        if (eq.size() != 0 || fsn != 3 || ufn != 5) begin
            errors++;
            $display("FAIL back_to_back_end: bytes left=%0d fs=%0d uf=%0d, expected 0 3 5", eq.size(), fsn, ufn);
        end
`ifdef BT656_TX_STATS_EN
        checks++;
        if (fr_cnt !== 16'd3 || uf_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stats: frame_cnt=%0d underflow_cnt=%0d, expected 3 5", fr_cnt, uf_cnt);
        end
`endif
    endtask

    task automatic test_reset_midline();
        logic rbad;
        set_cfg(4, 1, 4, 1);
        bq.push_back(mk(32'h44332211, 1'b1, 1'b0)); bq.push_back(mk(32'h88776655, 1'b0, 1'b1));
        enable = 1'b1;
        for (int c = 0; c < 36; c++) begin
            step(1'b1, rbad);
            enable = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bt656_data, bt656_valid, tready, frame_start, underflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: data=%h valid=%b ready=%b fs=%b uf=%b, expected 00 0 0 0 0",
                     bt656_data, bt656_valid, tready, frame_start, underflow);
        end
        @(posedge clk); #1;
        checks++;
        if ({bt656_data, bt656_valid, tready, frame_start, underflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset_next_cycle: data=%h valid=%b ready=%b fs=%b uf=%b, expected 00 0 0 0 0",
                     bt656_data, bt656_valid, tready, frame_start, underflow);
        end
        #2 rstn = 1'b1;
        bq.delete();
    endtask

    initial begin
        test_reset();
        test_frame(1);
        test_frame(2);
        test_underflow();
        test_vblank_flush();
        test_line_sync();
        test_back_to_back();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
